// File: rtl/vec_result_collector_if.sv
// Lane-result and register-file write bus between the vector ALU side and
// the result collector. The collector uses the slave modport.
interface vec_result_collector_if #(
  parameter int unsigned VLEN = 128
);
  logic [3:0]      lane_valid;
  logic [63:0]     lane_data0;
  logic [63:0]     lane_data1;
  logic [63:0]     lane_data2;
  logic [63:0]     lane_data3;
  logic [9:0]      lane_idx0;
  logic [9:0]      lane_idx1;
  logic [9:0]      lane_idx2;
  logic [9:0]      lane_idx3;
  logic            alu_done;
  logic            wr_valid;
  logic            wr_ready;
  logic [4:0]      wr_addr;
  logic [VLEN-1:0] wr_data;

  modport master (
    output lane_valid, lane_data0, lane_data1, lane_data2, lane_data3,
    output lane_idx0, lane_idx1, lane_idx2, lane_idx3, alu_done, wr_ready,
    input  wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  lane_valid, lane_data0, lane_data1, lane_data2, lane_data3,
    input  lane_idx0, lane_idx1, lane_idx2, lane_idx3, alu_done, wr_ready,
    output wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/vec_result_collector.sv
// Vector result collector: merges per-lane ALU slices into a VLEN-bit
// destination image and hands it to the register-file write port.
// Optional mask-undisturbed support is enabled by VEC_COLLECT_MASK_EN.
module vec_result_collector #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 4,
  parameter int unsigned NB_LANES   = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [4:0]                vd_addr,
  input  logic [2:0]                vsew,
`ifdef VEC_COLLECT_MASK_EN
  input  logic                      vm,
  input  logic [VLEN-1:0]           v0_mask,
  input  logic [VLEN-1:0]           vd_old,
`endif
  vec_result_collector_if.slave     bus,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf
);

  localparam int unsigned LANES  = 1 << NB_LANES;
  localparam int unsigned END_W  = 11;
  localparam int unsigned MIDX_W = $clog2(VLEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t          state_q;
  logic [VLEN-1:0] buf_q;
  logic [VLEN-1:0] buf_nxt;
  logic [4:0]      wr_addr_q;
  logic            wr_valid_q;
  logic [2:0]      vsew_q;
  logic            ovf_set;

  logic [63:0]     lane_data [4];
  logic [9:0]      lane_idx  [4];
  logic [3:0]      lane_en;
  logic [3:0]      slice_fit;
  logic [3:0]      mask_ok;
  logic [END_W-1:0] slice_end  [4];
  logic [VLEN-1:0] slice_mask [4];
  logic [VLEN-1:0] slice_data [4];

  logic [3:0]      sew_log;
  logic [3:0]      w_log;
  logic [6:0]      slice_w;
  logic [63:0]     w_mask;

  assign lane_data[0] = bus.lane_data0;
  assign lane_data[1] = bus.lane_data1;
  assign lane_data[2] = bus.lane_data2;
  assign lane_data[3] = bus.lane_data3;
  assign lane_idx[0]  = bus.lane_idx0;
  assign lane_idx[1]  = bus.lane_idx1;
  assign lane_idx[2]  = bus.lane_idx2;
  assign lane_idx[3]  = bus.lane_idx3;

  // Slice width is the element width capped at the lane datapath width.
  assign sew_log = {1'b0, vsew_q} + 4'd3;
  assign w_log   = (sew_log < 4'(LANE_WIDTH)) ? sew_log : 4'(LANE_WIDTH);
  assign slice_w = 7'(1) << w_log;
  assign w_mask  = (64'(1) << slice_w) - 64'd1;

`ifdef VEC_COLLECT_MASK_EN
  logic            vm_q;
  logic [VLEN-1:0] v0_mask_q;
`endif

  // Per-lane placement, range check and mask qualification.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < LANES) begin : g_used
      assign lane_en[i] = bus.lane_valid[i];
    end else begin : g_unused
      assign lane_en[i] = 1'b0;
    end
    assign slice_end[i]  = {1'b0, lane_idx[i]} + END_W'(slice_w);
    assign slice_fit[i]  = slice_end[i] <= END_W'(VLEN);
    assign slice_mask[i] = VLEN'(w_mask) << lane_idx[i];
    assign slice_data[i] = VLEN'(lane_data[i] & w_mask) << lane_idx[i];
`ifdef VEC_COLLECT_MASK_EN
    assign mask_ok[i] = vm_q | v0_mask_q[MIDX_W'(lane_idx[i] >> sew_log)];
`else
    assign mask_ok[i] = 1'b1;
`endif
  end

  // Merge this cycle's slices in lane order so the higher lane wins overlaps.
  always_comb begin
    buf_nxt = buf_q;
    ovf_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        if (!slice_fit[i]) begin
          ovf_set = 1'b1;
        end else if (mask_ok[i]) begin
          buf_nxt = (buf_nxt & ~slice_mask[i]) | slice_data[i];
        end
      end
    end
  end

  // Control FSM with registered outputs and destination buffer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      vsew_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
`ifdef VEC_COLLECT_MASK_EN
      vm_q       <= 1'b1;
      v0_mask_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= COLLECT;
            busy      <= 1'b1;
            wr_addr_q <= vd_addr;
            vsew_q    <= vsew;
            ovf       <= 1'b0;
`ifdef VEC_COLLECT_MASK_EN
            buf_q     <= vd_old;
            vm_q      <= vm;
            v0_mask_q <= v0_mask;
`else
            buf_q     <= '0;
`endif
          end
        end
        COLLECT: begin
          buf_q <= buf_nxt;
          if (ovf_set) ovf <= 1'b1;
          if (bus.alu_done) begin
            state_q    <= WRITE;
            wr_valid_q <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            state_q    <= IDLE;
            wr_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = buf_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Self-checking bench for vec_result_collector (default parameters).
// Define VEC_COLLECT_MASK_EN for both RTL and bench to exercise masking.
module tb_vec_result_collector;

  localparam int unsigned VLEN = 128;

  typedef struct packed {
    logic [4:0]      addr;
    logic [VLEN-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [4:0]      vd_addr;
  logic [2:0]      vsew;
  logic            busy;
  logic            done;
  logic            ovf;
`ifdef VEC_COLLECT_MASK_EN
  logic            vm;
  logic [VLEN-1:0] v0_mask;
  logic [VLEN-1:0] vd_old;
`endif

  vec_result_collector_if #(.VLEN(VLEN)) bus ();

  vec_result_collector #(.VLEN(VLEN), .LANE_WIDTH(4), .NB_LANES(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .vd_addr (vd_addr),
    .vsew    (vsew),
`ifdef VEC_COLLECT_MASK_EN
    .vm      (vm),
    .v0_mask (v0_mask),
    .vd_old  (vd_old),
`endif
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // Reference model of the collection in progress.
  logic [VLEN-1:0] m_buf;
  logic [4:0]      m_addr;
  logic [2:0]      m_vsew;
  logic            m_ovf;
  logic            m_vm;
  logic [VLEN-1:0] m_v0;

  function automatic void model_slice(input logic [9:0] idx, input logic [63:0] d);
    int w;
    int e;
    w = (m_vsew == 3'd0) ? 8 : 16;
    if (int'(idx) + w > int'(VLEN)) begin
      m_ovf = 1'b1;
    end else begin
      e = int'(idx) >> (int'(m_vsew) + 3);
      if (m_vm || m_v0[e]) begin
        for (int b = 0; b < w; b++) m_buf[int'(idx) + b] = d[b];
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] a, input logic [2:0] s, input logic with_done);
    start = 1'b1;
    vd_addr = a;
    vsew = s;
    bus.alu_done = with_done;
    m_addr = a;
    m_vsew = s;
    m_ovf = 1'b0;
`ifdef VEC_COLLECT_MASK_EN
    m_buf = vd_old;
    m_vm = vm;
    m_v0 = v0_mask;
`else
    m_buf = '0;
    m_vm = 1'b1;
    m_v0 = '0;
`endif
    step();
    start = 1'b0;
    bus.alu_done = 1'b0;
    checks++;
    if ({busy, bus.wr_valid, ovf} !== 3'b100) begin
      errors++;
      $display("FAIL start_state: busy/wr_valid/ovf=%b want 100", {busy, bus.wr_valid, ovf});
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [39:0] idxs,
                       input logic [255:0] datas, input logic dn);
    exp_t e;
    bus.lane_valid = v;
    bus.lane_idx0 = idxs[9:0];
    bus.lane_idx1 = idxs[19:10];
    bus.lane_idx2 = idxs[29:20];
    bus.lane_idx3 = idxs[39:30];
    bus.lane_data0 = datas[63:0];
    bus.lane_data1 = datas[127:64];
    bus.lane_data2 = datas[191:128];
    bus.lane_data3 = datas[255:192];
    bus.alu_done = dn;
    for (int i = 0; i < 4; i++)
      if (v[i]) model_slice(idxs[i*10 +: 10], datas[i*64 +: 64]);
    if (dn) begin
      e.addr = m_addr;
      e.data = m_buf;
      sb_q.push_back(e);
    end
    step();
    bus.lane_valid = 4'd0;
    bus.alu_done = 1'b0;
  endtask

  // Expects wr_valid the cycle after alu_done; stalls 'hold' cycles, then accepts.
  task automatic finish_write(input int hold, input string name);
    exp_t e;
    checks++;
    if (bus.wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wr_valid: got %b want 1", name, bus.wr_valid);
      return;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: got empty queue want one entry", name);
      return;
    end
    e = sb_q.pop_front();
    bus.wr_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      step();
      checks++;
      if (bus.wr_valid !== 1'b1 || done !== 1'b0 || bus.wr_data !== e.data || bus.wr_addr !== e.addr) begin
        errors++;
        $display("FAIL %s_stall%0d: valid=%b done=%b addr=%0d data=%h want 1 0 %0d %h",
                 name, c, bus.wr_valid, done, bus.wr_addr, bus.wr_data, e.addr, e.data);
      end
    end
    checks++;
    if (bus.wr_data !== e.data || bus.wr_addr !== e.addr) begin
      errors++;
      $display("FAIL %s_data: addr=%0d data=%h want %0d %h", name, bus.wr_addr, bus.wr_data, e.addr, e.data);
    end
    bus.wr_ready = 1'b1;
    step();
    bus.wr_ready = 1'b0;
    checks++;
    if ({done, busy, bus.wr_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s_handshake: done/busy/wr_valid=%b want 100", name, {done, busy, bus.wr_valid});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    checks++;
    if ({busy, done, ovf, bus.wr_valid} !== 4'b0000 || bus.wr_data !== '0 || bus.wr_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset: busy/done/ovf/valid=%b addr=%0d data=%h want 0000 0 0",
               {busy, done, ovf, bus.wr_valid}, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_assemble();
    do_start(5'd9, 3'd2, 1'b0);
    drive(4'hF, {10'd96, 10'd64, 10'd32, 10'd0},
          {64'h4444, 64'h3333, 64'h2222, 64'h1111}, 1'b0);
    drive(4'hF, {10'd112, 10'd80, 10'd48, 10'd16},
          {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 1'b1);
    checks++;
    if (bus.wr_data !== 128'hDDDD4444_CCCC3333_BBBB2222_AAAA1111 || bus.wr_addr !== 5'd9) begin
      errors++;
      $display("FAIL assemble_image: addr=%0d data=%h want 9 DDDD4444CCCC3333BBBB2222AAAA1111",
               bus.wr_addr, bus.wr_data);
    end
    finish_write(0, "assemble");
  endtask

  task automatic test_narrow_ovf();
    do_start(5'd2, 3'd0, 1'b0);
    drive(4'b0111, {10'd0, 10'd40, 10'd120, 10'd40},
          {64'h0, 64'h22, 64'h5A, 64'h11}, 1'b0);
    drive(4'b0001, {30'd0, 10'd8}, {192'd0, 64'h1FF}, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_inrange: got %b want 0", ovf);
    end
    drive(4'b0001, {30'd0, 10'd124}, {192'd0, 64'hAB}, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got %b want 1", ovf);
    end
    drive(4'b0000, 40'd0, 256'd0, 1'b1);
    checks++;
    if (bus.wr_data !== 128'h5A000000_00000000_00002200_0000FF00) begin
      errors++;
      $display("FAIL narrow_image: got %h want 5A00000000000000000022000000FF00", bus.wr_data);
    end
    finish_write(0, "narrow");
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_start(5'd12, 3'd1, 1'b0);
    drive(4'hF, {10'd48, 10'd32, 10'd16, 10'd0}, d, 1'b1);
    finish_write(5, "backpressure");
  endtask

  task automatic test_start_ignored();
    do_start(5'd3, 3'd3, 1'b1);
    step();
    checks++;
    if (bus.wr_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_with_done: wr_valid=%b busy=%b want 0 1", bus.wr_valid, busy);
    end
    start = 1'b1;
    vd_addr = 5'd7;
    drive(4'b0010, {20'd0, 10'd100, 10'd0}, {128'd0, 64'hBEEF, 64'h0}, 1'b0);
    drive(4'b1000, {10'd20, 30'd0}, {64'h1234, 192'd0}, 1'b1);
    start = 1'b0;
    finish_write(2, "start_ignored");
  endtask

  task automatic test_back_to_back();
    do_start(5'd20, 3'd2, 1'b0);
    drive(4'b0011, {20'd0, 10'd1000, 10'd0}, {128'd0, 64'hFFFF, 64'h7777}, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    sb_q.delete();
    checks++;
    if ({busy, bus.wr_valid, ovf, done} !== 4'b0000 || bus.wr_data !== '0 || bus.wr_addr !== 5'd0) begin
      errors++;
      $display("FAIL midreset: busy/valid/ovf/done=%b addr=%0d data=%h want 0000 0 0",
               {busy, bus.wr_valid, ovf, done}, bus.wr_addr, bus.wr_data);
    end
    do_start(5'd21, 3'd2, 1'b0);
    drive(4'b1000, {10'd64, 30'd0}, {64'h12345678, 192'd0}, 1'b1);
    checks++;
    if (bus.wr_data !== 128'h00000000_00005678_00000000_00000000) begin
      errors++;
      $display("FAIL post_reset_image: got %h want 00000000000056780000000000000000", bus.wr_data);
    end
    finish_write(1, "post_reset");
    do_start(5'd22, 3'd1, 1'b0);
    drive(4'b0101, {10'd0, 10'd112, 10'd0, 10'd0}, {64'h0, 64'hC0DE, 64'h0, 64'h5555}, 1'b1);
    finish_write(0, "back_to_back");
  endtask

`ifdef VEC_COLLECT_MASK_EN
  task automatic test_mask();
    vm = 1'b0;
    v0_mask = VLEN'(4'b0101);
    vd_old = '1;
    do_start(5'd4, 3'd2, 1'b0);
    drive(4'hF, {10'd48, 10'd32, 10'd16, 10'd0}, 256'd0, 1'b0);
    drive(4'hF, {10'd112, 10'd96, 10'd80, 10'd64}, 256'd0, 1'b1);
    checks++;
    if (bus.wr_data !== 128'hFFFFFFFF_00000000_FFFFFFFF_00000000) begin
      errors++;
      $display("FAIL mask_image: got %h want FFFFFFFF00000000FFFFFFFF00000000", bus.wr_data);
    end
    finish_write(0, "mask");
    vm = 1'b1;
    v0_mask = '0;
    vd_old = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    vd_addr = 5'd0;
    vsew = 3'd0;
    bus.lane_valid = 4'd0;
    bus.lane_data0 = '0;
    bus.lane_data1 = '0;
    bus.lane_data2 = '0;
    bus.lane_data3 = '0;
    bus.lane_idx0 = '0;
    bus.lane_idx1 = '0;
    bus.lane_idx2 = '0;
    bus.lane_idx3 = '0;
    bus.alu_done = 1'b0;
    bus.wr_ready = 1'b0;
`ifdef VEC_COLLECT_MASK_EN
    vm = 1'b1;
    v0_mask = '0;
    vd_old = '0;
`endif
    test_reset();
    test_assemble();
    test_narrow_ovf();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
`ifdef VEC_COLLECT_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
